// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types, crossbar port encoding and XY routing.
// Used by the input port and the crossbar so both agree on field positions and port codes.
package noc_pkg;

    localparam int FLIT_W  = 16;
    localparam int COORD_W = 3;

    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int DX_HI   = 13;
    localparam int DX_LO   = 11;
    localparam int DY_HI   = 10;
    localparam int DY_LO   = 8;
    localparam int PL_HI   = 7;
    localparam int PL_LO   = 0;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_SEND  = 2'd2
    } inport_state_e;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input logic [COORD_W-1:0] dx,
                                       input logic [COORD_W-1:0] dy,
                                       input logic [COORD_W-1:0] mx,
                                       input logic [COORD_W-1:0] my);
        if (dx > mx)      return PORT_E;
        else if (dx < mx) return PORT_W;
        else if (dy > my) return PORT_N;
        else if (dy < my) return PORT_S;
        else              return PORT_L;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous flit FIFO with registered occupancy count; full/empty derive from the count only.
module noc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/noc_input_port.sv
// NoC router input port: flit FIFO plus IDLE/ROUTE/SEND packet FSM with XY route computation.
// Optional NOC_INPORT_ERRCHK_EN drops non-head flits seen in IDLE and raises a sticky err_o.
//   state   | meaning
//   S_IDLE  | waiting for a head flit at the FIFO head; route latched on leaving
//   S_ROUTE | requesting the arbiter for route_port
//   S_SEND  | granted; forwarding flits until a tail is popped
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              route_req,
    output logic [2:0]        route_port,
    input  logic              grant,
    output logic              flit_valid_o,
    output logic [FLIT_W-1:0] flit_o,
    input  logic              out_ready,
    output logic              err_o
);

    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    inport_state_e     state_q, state_d;
    port_e             route_q, route_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FLIT_W-1:0] fifo_rdata;
    logic              drop_head;
    logic              send_fire;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign route_port = route_q;

    noc_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_flit),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef NOC_INPORT_ERRCHK_EN
    logic err_q, err_d;

    assign drop_head = !fifo_rdata[TYPE_LO];
    assign err_d     = err_q || (state_q == S_IDLE && !fifo_empty && drop_head);
    assign err_o     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign drop_head = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        route_d      = route_q;
        route_req    = 1'b0;
        flit_valid_o = 1'b0;
        flit_o       = '0;
        fifo_pop     = 1'b0;
        send_fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (drop_head) begin
                        fifo_pop = 1'b1;
                    end else begin
                        route_d = xy_route(fifo_rdata[DX_HI:DX_LO], fifo_rdata[DY_HI:DY_LO],
                                           MY_X_C, MY_Y_C);
                        state_d = S_ROUTE;
                    end
                end
            end
            S_ROUTE: begin
                route_req = 1'b1;
                if (grant) state_d = S_SEND;
            end
            S_SEND: begin
                route_req    = 1'b1;
                send_fire    = grant && !fifo_empty;
                flit_valid_o = send_fire;
                if (send_fire) flit_o = fifo_rdata;
                fifo_pop     = send_fire && out_ready;
                // Tail and head+tail both carry type bit 1 set.
                if (fifo_pop && fifo_rdata[TYPE_HI]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            route_q <= PORT_N;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

endmodule

// File: doc/noc_input_port.md
NOC_INPUT_PORT -- requirements
Module: noc_input_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in flits (power of two, ≥2).
REQ-002 SHALL have parameter MY_X, default 0, router X coordinate (3 bits).
REQ-003 SHALL have parameter MY_Y, default 0, router Y coordinate (3 bits).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream flit valid.
REQ-007 SHALL have port in_flit  input  16  upstream flit.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a flit.
REQ-009 SHALL have port route_req  output  1  request to arbiter for route_port.
REQ-010 SHALL have port route_port  output  3  requested output: N=0, S=1, E=2, W=3, L=4 (crossbar select encoding).
REQ-011 SHALL have port grant  input  1  arbiter grant; held by the arbiter for the whole packet.
REQ-012 SHALL have port flit_valid_o  output  1  flit_o valid toward crossbar.
REQ-013 SHALL have port flit_o  output  16  flit toward crossbar data input.
REQ-014 SHALL have port out_ready  input  1  granted output accepts the flit this cycle.
REQ-015 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-016 Flit format: [15:14] type (00 body, 01 head, 10 tail, 11 head+tail); head: [13:11] dest_x, [10:8] dest_y, [7:0] payload.
REQ-017 Push on in_valid && in_ready; in_ready = !full from registered count; no push when full, even with a same-cycle pop.
REQ-018 Pop on flit_valid_o && out_ready; simultaneous push and pop when not full leaves the count unchanged.
REQ-019 FSM states IDLE, ROUTE, SEND; reset state IDLE.
REQ-020 IDLE: if FIFO non-empty, register XY route of the head-of-FIFO flit into route_port and go to ROUTE next cycle.
REQ-021 XY route: dest_x>MY_X→E; dest_x<MY_X→W; else dest_y>MY_Y→N; dest_y<MY_Y→S; else L.
REQ-022 ROUTE: route_req=1; on grant=1 go to SEND next cycle; otherwise stay.
REQ-023 SEND: route_req=1; flit_valid_o = grant && !empty; flit_o = head-of-FIFO data.
REQ-024 SEND: popping a tail or head+tail flit returns to IDLE next cycle; route_req drops that cycle.
REQ-025 Grant deasserted during SEND: flit_valid_o=0, state held, no flit lost.
REQ-026 FIFO empty mid-packet in SEND: flit_valid_o=0, wait in SEND.
REQ-027 flit_o SHALL be 16'h0000 whenever flit_valid_o=0 (never X).
REQ-028 Minimum latency: head pushed in cycle 0 → route_req in cycle 2 → grant in cycle 2 → flit_valid_o in cycle 3.
REQ-029 route_port SHALL stay stable from ROUTE entry until the IDLE return.

Reset
REQ-030 On rst_n low: state IDLE, FIFO pointers and count 0, err_o=0, route_port=0, route_req=0, flit_valid_o=0, flit_o=0, in_ready=1 after release.
REQ-031 Reset mid-packet SHALL discard all buffered flits; no partial packet is forwarded after release.

Configuration
REQ-032 Macro NOC_INPORT_ERRCHK_EN: when defined, a body or tail flit at FIFO head in IDLE is popped and dropped without forwarding, and err_o is set until reset.
REQ-033 Without NOC_INPORT_ERRCHK_EN: the flit is routed as a head, and err_o is tied 0.

Structure
REQ-034 Package noc_pkg SHALL hold FLIT_W=16, the flit-type enum, the port enum (N,S,E,W,L), coordinate width 3, and field bit positions; the crossbar and this block SHALL share it.
REQ-035 Sub-module noc_fifo (parameterised DEPTH/width, registered count, full/empty) SHALL implement buffering.

Verification
REQ-036 MY=(1,1); push head dest (3,1), body, tail; grant held; out_ready=1 → route_port=2, three flits out in order, cycles 3-5.
REQ-037 Push 5 flits with DEPTH=4 and grant=0 → in_ready=0 after the 4th, 5th not accepted, no flit_valid_o.
REQ-038 Head+tail dest (1,1) → route_port=4, one flit out, IDLE, route_req=0 the next cycle.
REQ-039 Grant dropped for 2 cycles mid-packet → flit_valid_o=0 for those cycles, then remaining flits out unchanged.
REQ-040 Body flit first with NOC_INPORT_ERRCHK_EN → dropped, err_o=1 sticky; without the macro → routed, err_o=0.
REQ-041 rst_n asserted with 2 flits buffered → flit_valid_o=0, in_ready=1 after release, nothing forwarded.
